// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier: FSM encoding,
// product-width helper and two's-complement magnitude function.
package mult_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  // Widest operand the magnitude helper can handle.
  localparam int unsigned MAX_W = 64;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // Magnitude of the low w bits of v; negated only when signed and negative.
  // The most-negative value maps to 2^(w-1), which is exact as unsigned.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] v,
                                                input int unsigned      w,
                                                input logic             sgn);
    logic [MAX_W-1:0] mask;
    logic             msb;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    msb  = |(v & (MAX_W'(1) << (w - 1)));
    if (sgn && msb) begin
      return (~v + MAX_W'(1)) & mask;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder used for the partial-product accumulate.
// The final carry is not produced: the multiplier's sum never overflows.
module ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_in_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] carry;

  assign carry[0] = c_in_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ carry[gi];
    if (gi < N - 1) begin : g_carry
      assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Shift-add sequential multiplier with start/busy/done handshake, supporting
// unsigned and two's-complement operands and early exit on an empty multiplier.
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p_out
);

  localparam int PW = prod_width(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_out_q, p_out_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    acc_sum;

  assign mag_a = WIDTH'(twos_mag(MAX_W'(a_in), WIDTH, signed_mode));
  assign mag_b = WIDTH'(twos_mag(MAX_W'(b_in), WIDTH, signed_mode));

  ripple_adder #(
    .N(PW)
  ) u_add (
    .a_i   (p_q),
    .b_i   (a_q),
    .c_in_i(1'b0),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    neg_d   = neg_q;
    p_out_d = p_out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = PW'(mag_a);
          b_d     = mag_b;
          p_d     = '0;
          neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Empty multiplier means every remaining partial product is zero.
        if (b_q == '0) begin
          p_out_d = neg_q ? (~p_q + PW'(1)) : p_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (b_q[0]) begin
            p_d = acc_sum;
          end
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      p_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      p_out_q <= p_out_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == S_CALC);
  assign done  = done_q;
  assign p_out = p_out_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: stimulus pushes expected product and done
// cycle into a queue; an independent monitor checks each done pulse.
module tb_seq_mult_unit;

  typedef struct {
    logic [15:0] p;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] p_out;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  seq_mult_unit #(.WIDTH(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .signed_mode(signed_mode),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .p_out      (p_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got p_out=%h, expected no completion (cycle %0d)", p_out, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn: p_out=%h exp=%h done_cycle=%0d exp_cycle=%0d", p_out, e.p, cyc, e.done_cyc);
        check("product", 32'(p_out), 32'(e.p));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 after 50 cycles, expected busy=0");
    end
  endtask

  // lat = k+1: edges after the load edge until the completion edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] ep, input int lat);
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = s; start = 1'b1;
    sb_q.push_back('{p: ep, done_cyc: cyc + 1 + lat});
    @(negedge clk);
    start = 1'b0; a_in = ~a; b_in = 8'h5A; signed_mode = ~s;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_p_out", 32'(p_out), 32'd0);
    clr = 1'b1;

    run_op(8'd13,  8'd11,  1'b0, 16'd143,   5);
    run_op(8'hFD,  8'h05,  1'b1, 16'hFFF1,  4);
    run_op(8'd200, 8'd0,   1'b0, 16'h0000,  1);
    run_op(8'd0,   8'd255, 1'b0, 16'h0000,  9);
    run_op(8'h80,  8'h80,  1'b1, 16'h4000,  9);
    run_op(8'h80,  8'h7F,  1'b1, 16'hC080,  8);
    run_op(8'hFF,  8'hFF,  1'b0, 16'hFE01,  9);
    run_op(8'hFF,  8'hFF,  1'b1, 16'h0001,  2);
    run_op(8'h00,  8'hFB,  1'b1, 16'h0000,  4);
    run_op(8'hFD,  8'h05,  1'b0, 16'h04F1,  4);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    a_in = 8'd13; b_in = 8'd11; signed_mode = 1'b0; start = 1'b1;
    sb_q.push_back('{p: 16'd143, done_cyc: cyc + 1 + 5});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 8'd7; b_in = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("p_out_hold", 32'(p_out), 32'd143);
    check("idle_after_ignored", 32'(busy), 32'd0);

    // Start held high: two back-to-back results with one IDLE cycle between.
    @(negedge clk);
    a_in = 8'd3; b_in = 8'd3; signed_mode = 1'b0; start = 1'b1;
    sb_q.push_back('{p: 16'd9, done_cyc: cyc + 1 + 3});
    sb_q.push_back('{p: 16'd9, done_cyc: cyc + 1 + 7});
    repeat (4) @(negedge clk);
    check("idle_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("relaunch_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-calculation aborts without a done pulse.
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p_out", 32'(p_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_p_out", 32'(p_out), 32'd0);
    run_op(8'd13, 8'd11, 1'b0, 16'd143, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
